// File: rtl/mem_block_copier.sv
// mem_block_copier: memmove-style block copy or block fill engine driving the single-port data memory.
// Copy costs one READ and one WRITE per word; fill costs one WRITE per word.
module mem_block_copier #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  modo,
    input  logic [ADDR_WIDTH-1:0] origem,
    input  logic [ADDR_WIDTH-1:0] destino,
    input  logic [ADDR_WIDTH-1:0] tamanho,
    input  logic [DATA_WIDTH-1:0] padrao,
    output logic                  busy,
    output logic                  done,
    output logic                  erro,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] endereco,
    output logic [DATA_WIDTH-1:0] valor_escrita,
    input  logic [DATA_WIDTH-1:0] valor_saida
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t state_q, state_d;
    logic modo_q, modo_d, desc_q, desc_d, erro_q, erro_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pad_q, pad_d;
    logic [ADDR_WIDTH:0] src_end, dst_end;
    logic fail, desc;

    // Ends are one bit wider so out-of-range requests cannot wrap into a valid range
    assign src_end = {1'b0, origem} + {1'b0, tamanho};
    assign dst_end = {1'b0, destino} + {1'b0, tamanho};
    assign fail = (dst_end > DEPTH) || (!modo && src_end > DEPTH);
    assign desc = !modo && (destino > origem) && ({1'b0, destino} < src_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            modo_q  <= 1'b0;
            desc_q  <= 1'b0;
            erro_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            pad_q   <= '0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
            desc_q  <= desc_d;
            erro_q  <= erro_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        modo_d        = modo_q;
        desc_d        = desc_q;
        erro_d        = erro_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        pad_d         = pad_q;
        done          = 1'b0;
        erro          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        endereco      = '0;
        valor_escrita = '0;
        case (state_q)
            IDLE: if (start) begin
                modo_d  = modo;
                pad_d   = padrao;
                cnt_d   = tamanho;
                erro_d  = fail;
                desc_d  = desc;
                src_d   = desc ? origem + tamanho - 1'b1 : origem;
                dst_d   = desc ? destino + tamanho - 1'b1 : destino;
                state_d = (fail || tamanho == '0) ? DONE : (modo ? WRITE : READ);
            end
            READ: begin
                mem_read = 1'b1;
                endereco = src_q;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_write     = 1'b1;
                endereco      = dst_q;
                valor_escrita = modo_q ? pad_q : valor_saida;
                cnt_d         = cnt_q - 1'b1;
                src_d         = desc_q ? src_q - 1'b1 : src_q + 1'b1;
                dst_d         = desc_q ? dst_q - 1'b1 : dst_q + 1'b1;
                state_d       = (cnt_q == ADDR_WIDTH'(1)) ? DONE : (modo_q ? WRITE : READ);
            end
            DONE: begin
                done    = 1'b1;
                erro    = erro_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: directed table plus random requests against a memmove/fill model of the memory.
module tb_mem_block_copier;
    localparam int D = 50;

    logic clk = 1'b0;
    logic rst, start, modo;
    logic [5:0] origem, destino, tamanho;
    logic [7:0] padrao;
    logic busy, done, erro, mem_read, mem_write;
    logic [5:0] endereco;
    logic [7:0] valor_escrita, valor_saida;

    logic [7:0] mem [D];
    logic [7:0] ld_img [D];
    logic [7:0] ref_mem [D];
    logic ld_en = 1'b0;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic m;
        logic [5:0] o, d, l;
        logic [7:0] p;
        int intf, err, cyc;
    } vec_t;
    vec_t tbl [12];

    mem_block_copier dut (
        .clk(clk), .rst(rst), .start(start), .modo(modo), .origem(origem),
        .destino(destino), .tamanho(tamanho), .padrao(padrao), .busy(busy),
        .done(done), .erro(erro), .mem_read(mem_read), .mem_write(mem_write),
        .endereco(endereco), .valor_escrita(valor_escrita), .valor_saida(valor_saida)
    );

    always #5 clk = ~clk;

    // Memory with registered read data that holds while mem_read is low
    always @(posedge clk) begin
        if (ld_en)
            for (int i = 0; i < D; i++) mem[i] <= ld_img[i];
        else begin
            if (mem_read) valor_saida <= (endereco < D) ? mem[endereco] : 8'hxx;
            if (mem_write && endereco < D) mem[endereco] <= valor_escrita;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_mem(input string nm);
        int bad = 0;
        for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(nm, bad, 0);
    endtask

    function automatic bit model_ok(input logic m, input logic [5:0] o, d, l);
        return (int'(d) + int'(l) <= D) && (m || int'(o) + int'(l) <= D);
    endfunction

    function automatic int model_cyc(input logic m, input logic [5:0] o, d, l);
        if (!model_ok(m, o, d, l) || l == 0) return 1;
        return m ? int'(l) + 1 : 2 * int'(l) + 1;
    endfunction

    task automatic model_apply(input logic m, input logic [5:0] o, d, l, input logic [7:0] p);
        logic [7:0] tmp [$];
        if (!model_ok(m, o, d, l)) return;
        for (int k = 0; k < int'(l); k++) tmp.push_back(m ? p : ref_mem[int'(o) + k]);
        for (int k = 0; k < int'(l); k++) ref_mem[int'(d) + k] = tmp[k];
    endtask

    task automatic preload();
        for (int i = 0; i < D; i++) ld_img[i] = 8'(i * 7 + 3);
        ld_img[0] = 8'h11; ld_img[1] = 8'h22; ld_img[2] = 8'h33; ld_img[3] = 8'h44;
        for (int i = 5; i <= 9; i++) ld_img[i] = 8'(i - 4);
        for (int i = 0; i < D; i++) ref_mem[i] = ld_img[i];
        @(negedge clk) ld_en = 1'b1;
        @(negedge clk) ld_en = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [5:0] o, d, l, input logic [7:0] p,
                          input int intf, input int exp_err, input int exp_cyc);
        int got_cyc = -1, got_err = 0, rd = 0, wr = 0, both = 0, dones = 0;
        bit ok = model_ok(m, o, d, l);
        @(negedge clk);
        modo = m; origem = o; destino = d; tamanho = l; padrao = p; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        modo = 1'($urandom); origem = 6'($urandom); destino = 6'($urandom);
        tamanho = 6'($urandom); padrao = 8'($urandom);
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_start", busy, 1);
            if (c == intf) begin
                start = 1'b1; modo = ~m; origem = 6'd1; destino = 6'd0; tamanho = 6'd5;
            end else start = 1'b0;
            rd += int'(mem_read);
            wr += int'(mem_write);
            both += int'(mem_read && mem_write);
            if (got_cyc >= 0 && c == got_cyc + 1) chk("busy_idle", busy, 0);
            if (done) begin
                dones++;
                if (got_cyc < 0) begin got_cyc = c; got_err = int'(erro); end
            end
            if (got_cyc >= 0 && c >= got_cyc + 3) break;
        end
        start = 1'b0;
        model_apply(m, o, d, l, p);
        chk("done_cycle", got_cyc, exp_cyc);
        chk("erro", got_err, exp_err);
        chk("done_pulses", dones, 1);
        chk("reads", rd, (ok && !m) ? int'(l) : 0);
        chk("writes", wr, ok ? int'(l) : 0);
        chk("rw_overlap", both, 0);
        chk_mem("memory");
    endtask

    initial begin
        tbl[0]  = '{1'b0, 6'd0,  6'd10, 6'd4,  8'h00, 0,  0, 9};
        tbl[1]  = '{1'b0, 6'd5,  6'd7,  6'd5,  8'h00, 0,  0, 11};
        tbl[2]  = '{1'b0, 6'd7,  6'd5,  6'd3,  8'h00, 0,  0, 7};
        tbl[3]  = '{1'b1, 6'd0,  6'd45, 6'd5,  8'hA5, 0,  0, 6};
        tbl[4]  = '{1'b0, 6'd0,  6'd20, 6'd0,  8'h00, 0,  0, 1};
        tbl[5]  = '{1'b1, 6'd0,  6'd48, 6'd3,  8'h77, 0,  1, 1};
        tbl[6]  = '{1'b0, 6'd49, 6'd0,  6'd2,  8'h00, 0,  1, 1};
        tbl[7]  = '{1'b0, 6'd0,  6'd30, 6'd4,  8'h00, 3,  0, 9};
        tbl[8]  = '{1'b0, 6'd40, 6'd0,  6'd10, 8'h00, 21, 0, 21};
        tbl[9]  = '{1'b0, 6'd49, 6'd49, 6'd1,  8'h00, 0,  0, 3};
        tbl[10] = '{1'b1, 6'd0,  6'd50, 6'd0,  8'h66, 0,  0, 1};
        tbl[11] = '{1'b1, 6'd0,  6'd0,  6'd50, 8'h3C, 0,  0, 51};
        rst = 1'b1; start = 1'b0; modo = 1'b0; origem = '0; destino = '0; tamanho = '0; padrao = '0;
        #1;
        chk("reset_outputs", int'({busy, done, erro, mem_read, mem_write, endereco, valor_escrita}), 0);
        @(negedge clk) rst = 1'b0;
        preload();
        for (int i = 0; i < 12; i++)
            run_op(tbl[i].m, tbl[i].o, tbl[i].d, tbl[i].l, tbl[i].p, tbl[i].intf, tbl[i].err, tbl[i].cyc);

        // Abort an 8-word copy after its first two words have been written
        preload();
        @(negedge clk);
        modo = 1'b0; origem = 6'd0; destino = 6'd20; tamanho = 6'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outputs", int'({busy, done, erro, mem_read, mem_write, endereco, valor_escrita}), 0);
        @(negedge clk) rst = 1'b0;
        begin
            int dn = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                dn += int'(done);
            end
            chk("abort_no_done", dn, 0);
        end
        ref_mem[20] = ref_mem[0];
        ref_mem[21] = ref_mem[1];
        chk_mem("abort_memory");

        for (int n = 0; n < 40; n++) begin
            logic m;
            logic [5:0] o, d, l;
            int ec, intf;
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 49));
            d = ($urandom_range(0, 2) == 0) ? 6'((int'(o) + $urandom_range(0, 4)) % 64)
                                            : 6'($urandom_range(0, 49));
            ec = model_cyc(m, o, d, l);
            intf = (ec > 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, ec) : 0;
            run_op(m, o, d, l, 8'($urandom), intf, model_ok(m, o, d, l) ? 0 : 1, ec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Initiator-side engine for the single-port data memory: it drives that memory's mem_read, mem_write, endereco and valor_escrita, and consumes its registered valor_saida.
- Performs block copy (memmove semantics) or block fill over the 50-location, 8-bit memory.
- Sits beside the datapath; the control unit issues one start and waits for done.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 8, memory word width
MEM_DEPTH, 50, number of valid memory locations (addresses 0..MEM_DEPTH-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse, sampled only in IDLE
modo  input  1  0 = copy, 1 = fill
origem  input  ADDR_WIDTH  copy source base address
destino  input  ADDR_WIDTH  destination base address
tamanho  input  ADDR_WIDTH  number of words; 0 is legal
padrao  input  DATA_WIDTH  fill value
busy  output  1  high from the cycle after start is accepted until DONE is left
done  output  1  one-cycle completion pulse
erro  output  1  one-cycle pulse, coincident with done, on a rejected request
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
endereco  output  ADDR_WIDTH  memory address
valor_escrita  output  DATA_WIDTH  memory write data
valor_saida  input  DATA_WIDTH  memory read data; valid the cycle after mem_read, held while mem_read is low

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, erro, mem_read, mem_write = 0; endereco = 0; valor_escrita = 0.
- Outputs are decoded from state plus internal registers only. No input reaches an output combinationally, except valor_escrita = valor_saida in copy WRITE.
- States: IDLE, READ, WRITE, DONE.
- IDLE: on start=1, latch modo, origem, destino, tamanho and padrao.
- Range check, at least ADDR_WIDTH+1 bits wide:
  - fail if destino+tamanho > MEM_DEPTH;
  - in copy mode, also fail if origem+tamanho > MEM_DEPTH.
- Outcome of an accepted start:
  - Check fails: go to DONE with erro flagged; no memory access.
  - tamanho = 0: go to DONE; no memory access; erro = 0.
  - Copy: go to READ. Fill: go to WRITE.
- Direction (copy only): descending if destino > origem and destino < origem+tamanho; otherwise ascending.
  - Ascending: word k uses origem+k / destino+k.
  - Descending: word k uses origem+tamanho-1-k / destino+tamanho-1-k.
  - Fill is always ascending.
- READ: mem_read=1, endereco = current source address. Next state WRITE.
- WRITE:
  - mem_write=1, endereco = current destination address.
  - valor_escrita = valor_saida in copy, latched padrao in fill.
  - Decrement the remaining count. If it reaches 0, go to DONE; else advance addresses and go to READ (copy) or stay in WRITE (fill).
- mem_read and mem_write are never both 1 in any cycle.
- DONE: done=1; erro=1 only if the request was rejected. Next state IDLE. busy falls with DONE.
- Latency, measured from the clock edge that samples start (edge 0):
  - copy of N words: done high in cycle 2N+1;
  - fill of N words: done high in cycle N+1;
  - zero length or error: done high in cycle 1.
- start while not in IDLE (including DONE) is ignored and never queued. Input changes after acceptance have no effect.
- Outside READ/WRITE: endereco=0, valor_escrita=0, strobes low.
- Reset mid-transfer: immediate return to IDLE. Memory retains the words already written. No done is produced for the aborted request.

Test Plan:
- Copy, no overlap: mem[0..3]=11,22,33,44; start modo=0 origem=0 destino=10 tamanho=4 -> mem[10..13]=11,22,33,44, done in cycle 9, erro=0, source unchanged.
- Overlapping copy, forward shift: mem[5..9]=1..5; origem=5 destino=7 tamanho=5 -> descending order; mem[7..11]=1,2,3,4,5 and mem[5..6]=1,2. Also origem=7 destino=5 tamanho=3 -> ascending order.
- Fill: destino=45 tamanho=5 padrao=A5 -> mem[45..49]=A5, done in cycle 6, mem_read never asserted.
- Zero length and range errors:
  - tamanho=0 -> done in cycle 1 with erro=0 and no strobes.
  - destino=48 tamanho=3 -> done=erro=1 in cycle 1, no strobes.
  - copy with origem=49 tamanho=2 -> erro=1.
- Start during busy: second start mid-copy with different arguments -> ignored, first transfer completes exactly, single done pulse.
- Reset mid-copy: assert rst after 2 words of an 8-word copy -> all outputs 0 immediately, no done, first 2 destination words written, remaining destinations untouched; a new start afterwards works normally.
